// File: rtl/ps2_key_receiver_if.sv
// PS/2 keyboard pins in, decoded key / error strobes out.
// Latency: n/a (signal bundle only).
// Backpressure: none; key_valid and frame_err are single-cycle strobes.
// Ports: ps2_clk/ps2_data (raw, asynchronous keyboard pins), key_ascii (held key),
//        key_valid (update strobe), frame_err (bad or abandoned frame strobe).
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       frame_err;

    // Driver side: the keyboard model / upstream pins.
    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_ascii,
        input  key_valid,
        input  frame_err
    );

    // Receiver side.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_ascii,
        output key_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 set-2 receiver: filters ps2_clk, deserializes frames, maps f/c/s make codes to ASCII.
// Latency: key_valid / frame_err one clk after the filtered ps2_clk falling edge of the stop bit.
// Backpressure: none; the keyboard cannot be stalled, consumers must take the strobes as they come.
// Ports: clk, rst_n (async active-low), bus (slave modport: ps2_clk, ps2_data in;
//        key_ascii, key_valid, frame_err out).
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps2_key_receiver_if.slave    bus
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Synchronizers idle high, matching the released PS/2 lines.
    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_clk_q;
    logic [FW-1:0] filt_cnt_q;
    logic          fall_edge;

    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          brk_q, ext_q;
    logic [7:0]    key_ascii_q;
    logic          key_valid_q;
    logic          frame_err_q;

    logic          parity_ok;
    logic          map_hit_d;
    logic [7:0]    map_ascii_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= bus.ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the level only flips after FILTER_LEN consecutive
    // synchronized samples disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_clk_q <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    // High in the one cycle whose clock edge moves the filtered clock 1->0.
    assign fall_edge = filt_clk_q & ~clk_s2_q & (filt_cnt_q == FILT_MAX);

    // Odd parity across the eight data bits plus the parity bit.
    assign parity_ok = ^{shift_q, par_q};

    always_comb begin
        map_hit_d   = 1'b1;
        map_ascii_d = 8'h00;
        case (shift_q)
            8'h2B:   map_ascii_d = 8'h66;
            8'h21:   map_ascii_d = 8'h63;
            8'h1B:   map_ascii_d = 8'h73;
            default: map_hit_d   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            key_ascii_q <= 8'h00;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
                if (fall_edge) begin
                    if (!dat_s2_q) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
            end else if (fall_edge) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        if (dat_s2_q && parity_ok) begin
                            if (shift_q == 8'hF0) begin
                                brk_q <= 1'b1;
                            end else if (shift_q == 8'hE0) begin
                                ext_q <= 1'b1;
                            end else if (brk_q || ext_q) begin
                                // Break or extended key: swallow the code that follows the prefix.
                                brk_q <= 1'b0;
                                ext_q <= 1'b0;
                            end else if (map_hit_d) begin
                                key_ascii_q <= map_ascii_d;
                                key_valid_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                endcase
            end else if (to_cnt_q == TO_MAX) begin
                // Keyboard went quiet mid-frame: drop it and any pending prefix.
                state_q     <= ST_IDLE;
                to_cnt_q    <= '0;
                brk_q       <= 1'b0;
                ext_q       <= 1'b0;
                frame_err_q <= 1'b1;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign bus.key_ascii = key_ascii_q;
    assign bus.key_valid = key_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed-frame bench for ps2_key_receiver with a queue-based scoreboard.
// Latency: expected pulses carry the exact clk cycle they must appear in.
// Backpressure: none; the monitor consumes every strobe the DUT raises.
module tb_ps2_key_receiver;

    localparam int H   = 40;   // clk cycles per ps2_clk half period
    localparam int TO  = 400;  // TIMEOUT_CYCLES used for this bench
    localparam int FL  = 8;    // FILTER_LEN
    localparam int LAT = 2 + FL; // driven ps2_clk fall -> output visible, in clk cycles

    typedef struct {
        int         kind;   // 1 = key_valid, 2 = frame_err
        logic [7:0] ascii;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   mon_kind;
    logic [7:0] prev_ascii = 8'h00;

    ps2_key_receiver_if bus ();

    ps2_key_receiver #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data set while the clock is high, then a falling edge.
    task automatic drive_bit(input logic b, input bit push, input int kind,
                             input logic [7:0] asc, input int extra);
        bus.ps2_data = b;
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b0;
        if (push) sb_q.push_back('{kind, asc, cyc + LAT + extra});
        repeat (H) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame. kind != 0 queues one expected pulse tied
    // to the last bit sent; a truncated frame expects its pulse a timeout later.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input int kind, input logic [7:0] asc);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            drive_bit(f[i], (i == nbits - 1) && (kind != 0), kind, asc,
                      (nbits < 11) ? TO : 0);
        end
        bus.ps2_data = 1'b1;
        if (nbits == 11) repeat (2 * H) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.key_valid && bus.frame_err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL strobe_overlap: key_valid=1 frame_err=1 at cyc %0d, required not both", cyc);
            end else if (bus.key_valid || bus.frame_err) begin
                n_cmp++;
                mon_kind = bus.key_valid ? 1 : 2;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_pulse: kind=%0d ascii=%02h cyc=%0d, required no pulse",
                             mon_kind, bus.key_ascii, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_kind != mon_e.kind ||
                        (mon_kind == 1 && bus.key_ascii !== mon_e.ascii) ||
                        cyc != mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL sb_pulse: got kind=%0d ascii=%02h cyc=%0d, required kind=%0d ascii=%02h cyc=%0d",
                                 mon_kind, bus.key_ascii, cyc, mon_e.kind, mon_e.ascii, mon_e.cyc);
                    end
                end
            end
            if (bus.key_ascii !== prev_ascii && !bus.key_valid) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ascii_without_valid: got %02h, required %02h", bus.key_ascii, prev_ascii);
            end
        end
        prev_ascii = bus.key_ascii;
    end

    initial begin
        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_ascii", {24'd0, bus.key_ascii}, 32'h00);
        chk("reset_valid", {31'd0, bus.key_valid}, 32'h0);
        chk("reset_err",   {31'd0, bus.frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Plain make code for "f".
        send_frame(8'h2B, 1'b0, 11, 1, 8'h66);
        chk("f_ascii", {24'd0, bus.key_ascii}, 32'h66);

        // "c", then its break pair which must stay silent.
        send_frame(8'h21, 1'b0, 11, 1, 8'h63);
        send_frame(8'hF0, 1'b0, 11, 0, 8'h00);
        send_frame(8'h21, 1'b0, 11, 0, 8'h00);
        chk("break_hold", {24'd0, bus.key_ascii}, 32'h63);

        // Bad parity on "s", then a clean "s".
        send_frame(8'h1B, 1'b1, 11, 2, 8'h00);
        chk("parity_hold", {24'd0, bus.key_ascii}, 32'h63);
        send_frame(8'h1B, 1'b0, 11, 1, 8'h73);
        chk("s_ascii", {24'd0, bus.key_ascii}, 32'h73);

        // Start + 4 data bits, then silence past the timeout.
        send_frame(8'h2B, 1'b0, 5, 2, 8'h00);
        repeat (TO + 100) @(negedge clk);
        chk("timeout_hold", {24'd0, bus.key_ascii}, 32'h73);
        send_frame(8'h2B, 1'b0, 11, 1, 8'h66);
        chk("after_timeout", {24'd0, bus.key_ascii}, 32'h66);

        // Typematic repeat: same value, fresh pulse.
        send_frame(8'h2B, 1'b0, 11, 1, 8'h66);
        chk("repeat_ascii", {24'd0, bus.key_ascii}, 32'h66);

        // Extended prefix swallows the next code; unmapped code is ignored.
        send_frame(8'hE0, 1'b0, 11, 0, 8'h00);
        send_frame(8'h2B, 1'b0, 11, 0, 8'h00);
        send_frame(8'h1C, 1'b0, 11, 0, 8'h00);
        chk("ext_unmapped_hold", {24'd0, bus.key_ascii}, 32'h66);

        // 2-cycle low glitch with data high: sampling it would flag an error.
        bus.ps2_data = 1'b1;
        bus.ps2_clk  = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_hold", {24'd0, bus.key_ascii}, 32'h66);

        // Reset after 5 data bits: outputs clear at once, frame is discarded.
        send_frame(8'h21, 1'b0, 6, 0, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("midreset_ascii", {24'd0, bus.key_ascii}, 32'h00);
        chk("midreset_valid", {31'd0, bus.key_valid}, 32'h0);
        chk("midreset_err",   {31'd0, bus.frame_err}, 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h21, 1'b0, 11, 1, 8'h63);
        chk("post_reset_c", {24'd0, bus.key_ascii}, 32'h63);

        repeat (50) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
- Receives PS/2 keyboard frames (scan code set 2) on the board's PS/2 pins.
- Validates each frame and tracks break/extended prefixes.
- Translates the make codes for the mode keys to lowercase ASCII and holds the last accepted key on an 8-bit bus.
- Sits directly upstream of the PS/2-to-7-segment text decoder (ps2Data input), which shows FAST / ChUP / SLID.

Parameters:
- FILTER_LEN, 8, consecutive identical synchronized samples required before the filtered ps2_clk level changes (sets counter width).
- TIMEOUT_CYCLES, 100000, clk cycles without a filtered ps2_clk falling edge before an in-progress frame is abandoned (1 ms at 100 MHz).

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst_n  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous
- ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous
- key_ascii  output  8  last accepted key as ASCII ("f"=8'h66, "c"=8'h63, "s"=8'h73); held between keys
- key_valid  output  1  one-cycle pulse when key_ascii is updated
- frame_err  output  1  one-cycle pulse on parity/start/stop error or timeout

Behaviour:
- Reset (async, rst_n=0):
  - key_ascii=8'h00, key_valid=0, frame_err=0.
  - FSM=IDLE; break and ext flags cleared; shift register, bit counter, timeout counter and filter counter cleared.
  - Filtered ps2_clk state=1.
  - A reset during a frame discards that frame with no pulses.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock changes level only after FILTER_LEN consecutive synchronized samples differ from its current level.
  - fall_edge = one-cycle strobe when the filtered clock goes 1->0. ps2_data (synchronized) is sampled on fall_edge only.
- FSM (all transitions on fall_edge unless noted):
  - IDLE: sampled data=0 (start bit) -> DATA, bit count=0. Sampled data=1 -> stay in IDLE, frame_err=1.
  - DATA: shift in 8 bits LSB first; after the 8th -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: sampled data=1 and odd parity over data+parity -> frame accepted. Otherwise frame_err=1. Either way -> IDLE.
- Timeout:
  - In DATA/PARITY/STOP, the counter increments every clk and clears on fall_edge.
  - At TIMEOUT_CYCLES-1: -> IDLE, frame_err=1, break/ext flags cleared.
  - The counter is idle in IDLE.
- Accepted byte handling, evaluated the cycle after the STOP fall_edge:
  - 8'hF0: set break flag; no output.
  - 8'hE0: set ext flag; no output.
  - Otherwise, if break or ext flag is set: clear both flags; no output.
  - Otherwise map 8'h2B->"f", 8'h21->"c", 8'h1B->"s": load key_ascii and pulse key_valid in the same cycle.
  - Unmapped codes: no output, key_ascii unchanged.
- Latency: key_valid rises exactly 1 clk after the fall_edge strobe that samples the stop bit. frame_err for a stop/parity error also rises 1 clk after that strobe.
- key_valid and frame_err are never high in the same cycle.
- key_ascii changes only together with key_valid.
- The same key repeated (typematic) pulses key_valid each time, with an unchanged value.
- Host-to-device transmission is not supported; ps2_clk and ps2_data are inputs only.

Test Plan:
- Frame for 8'h2B (start 0, data LSB first, odd parity 1, stop 1), ps2_clk period 80 us -> key_ascii=8'h66, key_valid high exactly 1 clk, 1 clk after the last fall_edge; frame_err stays 0.
- Sequence 8'h21, then 8'hF0 8'h21 -> key_valid once with key_ascii=8'h63; break pair produces no pulse; key_ascii stays 8'h63.
- Frame 8'h1B with a flipped parity bit -> frame_err one pulse, no key_valid, key_ascii unchanged. Next good 8'h1B frame -> key_ascii=8'h73.
- Stop ps2_clk after 4 data bits for more than TIMEOUT_CYCLES -> frame_err pulse at the timeout cycle, FSM back in IDLE. Next full 8'h2B frame decodes to 8'h66.
- 8'hE0 8'h2B, then unmapped 8'h1C -> no key_valid for either; key_ascii unchanged. A 2-clk-wide glitch on ps2_clk (FILTER_LEN=8) produces no sampling.
- Assert rst_n low mid-frame (after 5 data bits) -> outputs go to 0 immediately. After release, a complete 8'h21 frame yields key_ascii=8'h63 with no frame_err.
